// File: rtl/pipe_datapath.sv
`default_nettype none
//==============================================================================
// Module   : pipe_datapath
// Purpose  : Three-stage (X/M/W) execute/memory/writeback datapath registers
//            with operand selection, result selection, stall/flush control and
//            either M/W -> X operand bypass or RAW hazard indication.
// Config   : PIPE_DATAPATH_FWD_EN defined   -> bypass active, hazard_o = 0
//            PIPE_DATAPATH_FWD_EN undefined -> no bypass, hazard_o flags RAW
// Revision : 1.0 - initial release
//==============================================================================
module pipe_datapath #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            d_valid_i,
   input  logic [RA_W-1:0] rs1_addr_i,
   input  logic [RA_W-1:0] rs2_addr_i,
   input  logic [RA_W-1:0] rd_addr_i,
   input  logic            rd_we_i,
   input  logic [XLEN-1:0] reg1_data_i,
   input  logic [XLEN-1:0] reg2_data_i,
   input  logic [XLEN-1:0] imm_signed_i,
   input  logic [XLEN-1:0] pc_val_d2_i,
   input  logic            op1_sel_i,
   input  logic            op2_sel_i,
   input  logic [1:0]      alu_sel_i,
   input  logic [1:0]      w_sel_i,
   input  logic [XLEN-1:0] arith_out_i,
   input  logic [XLEN-1:0] logical_out_i,
   input  logic [XLEN-1:0] shift_out_i,
   input  logic [XLEN-1:0] load_data_i,
   output logic [XLEN-1:0] x_op1_o,
   output logic [XLEN-1:0] x_op2_o,
   output logic            x_valid_o,
   output logic [XLEN-1:0] m_alu_data_o,
   output logic            m_valid_o,
   output logic [XLEN-1:0] w_data_o,
   output logic [RA_W-1:0] w_rd_addr_o,
   output logic            w_we_o,
   output logic            hazard_o
);

   localparam logic [1:0]      c_alu_logic = 2'd1;
   localparam logic [1:0]      c_alu_shift = 2'd2;
   localparam logic [1:0]      c_wb_load   = 2'd1;
   localparam logic [1:0]      c_wb_pc4    = 2'd2;
   localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);

   // X stage
   logic            r_x_valid;
   logic [RA_W-1:0] r_x_rd_addr;
   logic            r_x_rd_we;
   logic [1:0]      r_x_w_sel;
   logic [1:0]      r_x_alu_sel;
   logic [XLEN-1:0] r_x_pc4;
   logic [XLEN-1:0] r_x_op1;
   logic [XLEN-1:0] r_x_op2;
   // M stage
   logic            r_m_valid;
   logic [RA_W-1:0] r_m_rd_addr;
   logic            r_m_rd_we;
   logic [1:0]      r_m_w_sel;
   logic [XLEN-1:0] r_m_pc4;
   logic [XLEN-1:0] r_m_alu_data;
   // W stage (r_wb_we already folds in valid & rd_we)
   logic [XLEN-1:0] r_wb_data;
   logic [RA_W-1:0] r_wb_rd_addr;
   logic            r_wb_we;

   logic            w_advance;
   logic [XLEN-1:0] w_alu_result;
   logic [XLEN-1:0] w_m_result;
   logic            w_m_hit1;
   logic            w_m_hit2;
   logic            w_wb_hit1;
   logic            w_wb_hit2;
   logic [XLEN-1:0] w_fwd1;
   logic [XLEN-1:0] w_fwd2;

   // Flush forces the stages to move even when stalled.
   assign w_advance = ~stall_i | flush_i;

   // Pick the external unit result for the instruction currently in X.
   always_comb begin
      w_alu_result = arith_out_i;
      case (r_x_alu_sel)
         c_alu_logic: w_alu_result = logical_out_i;
         c_alu_shift: w_alu_result = shift_out_i;
         default:     w_alu_result = arith_out_i;
      endcase
   end

   // Value the W stage would capture from M; also the M-stage bypass value.
   always_comb begin
      w_m_result = r_m_alu_data;
      case (r_m_w_sel)
         c_wb_load: w_m_result = load_data_i;
         c_wb_pc4:  w_m_result = r_m_pc4;
         default:   w_m_result = r_m_alu_data;
      endcase
   end

   // Producer matches; register 0 is hard-wired and never matches.
   assign w_m_hit1  = r_m_valid & r_m_rd_we & (r_m_rd_addr == rs1_addr_i) & (rs1_addr_i != '0);
   assign w_m_hit2  = r_m_valid & r_m_rd_we & (r_m_rd_addr == rs2_addr_i) & (rs2_addr_i != '0);
   assign w_wb_hit1 = r_wb_we & (r_wb_rd_addr == rs1_addr_i) & (rs1_addr_i != '0);
   assign w_wb_hit2 = r_wb_we & (r_wb_rd_addr == rs2_addr_i) & (rs2_addr_i != '0);

`ifdef PIPE_DATAPATH_FWD_EN
   // Youngest producer wins: M result, then W data, then register file.
   always_comb begin
      w_fwd1 = reg1_data_i;
      w_fwd2 = reg2_data_i;
      if (w_m_hit1)       w_fwd1 = w_m_result;
      else if (w_wb_hit1) w_fwd1 = r_wb_data;
      if (w_m_hit2)       w_fwd2 = w_m_result;
      else if (w_wb_hit2) w_fwd2 = r_wb_data;
   end
   assign hazard_o = 1'b0;
`else
   assign w_fwd1   = reg1_data_i;
   assign w_fwd2   = reg2_data_i;
   // Only register-selected operands can depend on an in-flight result.
   assign hazard_o = d_valid_i & ((~op1_sel_i & (w_m_hit1 | w_wb_hit1)) |
                                  (~op2_sel_i & (w_m_hit2 | w_wb_hit2)));
`endif

   // X stage capture: operand muxing and control from decode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_x_valid   <= 1'b0;
         r_x_rd_addr <= '0;
         r_x_rd_we   <= 1'b0;
         r_x_w_sel   <= 2'd0;
         r_x_alu_sel <= 2'd0;
         r_x_pc4     <= '0;
         r_x_op1     <= '0;
         r_x_op2     <= '0;
      end else if (w_advance) begin
         r_x_valid   <= d_valid_i & ~flush_i;
         r_x_rd_addr <= rd_addr_i;
         r_x_rd_we   <= rd_we_i;
         r_x_w_sel   <= w_sel_i;
         r_x_alu_sel <= alu_sel_i;
         r_x_pc4     <= pc_val_d2_i + c_pc_step;
         r_x_op1     <= op1_sel_i ? pc_val_d2_i : w_fwd1;
         r_x_op2     <= op2_sel_i ? imm_signed_i : w_fwd2;
      end
   end

   // M stage capture: latch the selected execution-unit result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_m_valid    <= 1'b0;
         r_m_rd_addr  <= '0;
         r_m_rd_we    <= 1'b0;
         r_m_w_sel    <= 2'd0;
         r_m_pc4      <= '0;
         r_m_alu_data <= '0;
      end else if (w_advance) begin
         r_m_valid    <= r_x_valid & ~flush_i;
         r_m_rd_addr  <= r_x_rd_addr;
         r_m_rd_we    <= r_x_rd_we;
         r_m_w_sel    <= r_x_w_sel;
         r_m_pc4      <= r_x_pc4;
         r_m_alu_data <= w_alu_result;
      end
   end

   // W stage capture; write enable drops while stalled so a held result is
   // written back exactly once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wb_data    <= '0;
         r_wb_rd_addr <= '0;
         r_wb_we      <= 1'b0;
      end else if (w_advance) begin
         r_wb_data    <= w_m_result;
         r_wb_rd_addr <= r_m_rd_addr;
         r_wb_we      <= r_m_valid & r_m_rd_we;
      end else begin
         r_wb_we      <= 1'b0;
      end
   end

   assign x_op1_o      = r_x_op1;
   assign x_op2_o      = r_x_op2;
   assign x_valid_o    = r_x_valid;
   assign m_alu_data_o = r_m_alu_data;
   assign m_valid_o    = r_m_valid;
   assign w_data_o     = r_wb_data;
   assign w_rd_addr_o  = r_wb_rd_addr;
   assign w_we_o       = r_wb_we;

endmodule
`default_nettype wire

// File: tb/tb_pipe_datapath.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipe_datapath
// Purpose  : Directed self-checking bench for pipe_datapath.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pipe_datapath;

`ifdef PIPE_DATAPATH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk, rst, stall, flush, d_valid, rd_we, op1_sel, op2_sel;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] reg1, reg2, imm, pc;
   logic [1:0]  alu_sel, w_sel;
   logic [31:0] arith, logical, shift, load;
   logic [31:0] x_op1, x_op2, m_alu, w_data;
   logic        x_valid, m_valid, w_we, hazard;
   logic [4:0]  w_rd;
   logic [31:0] exp_v;
   logic        exp_h;
   int          total = 0;
   int          bad = 0;

   pipe_datapath #(.XLEN(32), .RA_W(5)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .d_valid_i(d_valid), .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rd_addr_i(rd),
      .rd_we_i(rd_we), .reg1_data_i(reg1), .reg2_data_i(reg2),
      .imm_signed_i(imm), .pc_val_d2_i(pc), .op1_sel_i(op1_sel),
      .op2_sel_i(op2_sel), .alu_sel_i(alu_sel), .w_sel_i(w_sel),
      .arith_out_i(arith), .logical_out_i(logical), .shift_out_i(shift),
      .load_data_i(load), .x_op1_o(x_op1), .x_op2_o(x_op2),
      .x_valid_o(x_valid), .m_alu_data_o(m_alu), .m_valid_o(m_valid),
      .w_data_o(w_data), .w_rd_addr_o(w_rd), .w_we_o(w_we), .hazard_o(hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                        input logic [4:0] a_rd, input logic a_we,
                        input logic [31:0] a_r1, input logic [31:0] a_r2,
                        input logic [31:0] a_imm, input logic [31:0] a_pc,
                        input logic a_o1, input logic a_o2,
                        input logic [1:0] a_alu, input logic [1:0] a_ws);
      d_valid = 1'b1; rs1 = a_rs1; rs2 = a_rs2; rd = a_rd; rd_we = a_we;
      reg1 = a_r1; reg2 = a_r2; imm = a_imm; pc = a_pc;
      op1_sel = a_o1; op2_sel = a_o2; alu_sel = a_alu; w_sel = a_ws;
   endtask

   task automatic bubble();
      d_valid = 1'b0; rd_we = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
   endtask

   task automatic drain();
      bubble();
      repeat (3) step();
   endtask

   task automatic test_reset();
      #2;
      total++; if (x_op1 !== 32'h0) begin bad++; $display("FAIL rst_x_op1: got %h want 0", x_op1); end
      total++; if ({x_valid, m_valid, w_we} !== 3'b000) begin bad++; $display("FAIL rst_valids: got %b want 000", {x_valid, m_valid, w_we}); end
      total++; if (w_data !== 32'h0) begin bad++; $display("FAIL rst_w_data: got %h want 0", w_data); end
      issue(5'd0, 5'd0, 5'd1, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0, 1'b0, 2'd0, 2'd0);
      step();
      total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_x_valid: got %b want 0", x_valid); end
      #2 rst = 1'b0;
      bubble();
      step();
   endtask

   task automatic test_latency();
      drain();
      issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h100, 32'h0, 32'h20, 32'h40, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      bubble(); arith = 32'h120;
      total++; if (x_valid !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL lat_e1_valid: got x=%b m=%b want x=1 m=0", x_valid, m_valid); end
      total++; if (x_op1 !== 32'h100 || x_op2 !== 32'h20) begin bad++; $display("FAIL lat_ops: got %h/%h want 100/20", x_op1, x_op2); end
      step();
      total++; if (m_valid !== 1'b1 || x_valid !== 1'b0 || m_alu !== 32'h120) begin bad++; $display("FAIL lat_e2: got m=%b x=%b alu=%h want 1 0 120", m_valid, x_valid, m_alu); end
      step();
      total++; if (w_we !== 1'b1 || w_data !== 32'h120 || w_rd !== 5'd7) begin bad++; $display("FAIL lat_e3_wb: got we=%b d=%h rd=%0d want 1 120 7", w_we, w_data, w_rd); end
      step();
      total++; if (w_we !== 1'b0) begin bad++; $display("FAIL lat_e4_we: got %b want 0", w_we); end
   endtask

   task automatic test_alu_select();
      drain();
      arith = 32'h111; logical = 32'h222; shift = 32'h333; load = 32'h999;
      issue(5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd1, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd2, 1'b1, 32'h2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd2, 2'd0);
      step();
      total++; if (m_alu !== 32'h222) begin bad++; $display("FAIL alu_logic: got %h want 222", m_alu); end
      issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd3, 2'd3);
      step();
      total++; if (m_alu !== 32'h333 || w_data !== 32'h222) begin bad++; $display("FAIL alu_shift: got m=%h w=%h want 333 222", m_alu, w_data); end
      bubble();
      step();
      total++; if (m_alu !== 32'h111) begin bad++; $display("FAIL alu_reserved: got %h want 111", m_alu); end
      step();
      total++; if (w_data !== 32'h111 || w_rd !== 5'd3 || w_we !== 1'b1) begin bad++; $display("FAIL wsel_reserved: got d=%h rd=%0d we=%b want 111 3 1", w_data, w_rd, w_we); end
   endtask

   task automatic test_load_pc4();
      drain();
      issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 2'd0, 2'd2);
      step();
      issue(5'd0, 5'd0, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd1);
      step();
      bubble(); load = 32'hCAFE_0001;
      step();
      total++; if (w_data !== 32'h0 || w_rd !== 5'd9 || w_we !== 1'b1) begin bad++; $display("FAIL pc4_wrap: got d=%h rd=%0d we=%b want 0 9 1", w_data, w_rd, w_we); end
      step();
      total++; if (w_data !== 32'hCAFE_0001 || w_rd !== 5'd10) begin bad++; $display("FAIL load_wb: got d=%h rd=%0d want cafe0001 10", w_data, w_rd); end
   endtask

   task automatic test_back_to_back();
      drain();
      issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      bubble(); arith = 32'h10;
      step();
      issue(5'd3, 5'd0, 5'd14, 1'b1, 32'hDEAD, 32'h0, 32'h4, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      #1;
      exp_h = !FWD;
      total++; if (hazard !== exp_h) begin bad++; $display("FAIL b2b_hazard: got %b want %b", hazard, exp_h); end
      op1_sel = 1'b1; #1;
      total++; if (hazard !== 1'b0) begin bad++; $display("FAIL b2b_pc_no_hazard: got %b want 0", hazard); end
      op1_sel = 1'b0; d_valid = 1'b0; #1;
      total++; if (hazard !== 1'b0) begin bad++; $display("FAIL b2b_invalid_no_hazard: got %b want 0", hazard); end
      d_valid = 1'b1;
      step();
      exp_v = FWD ? 32'h10 : 32'hDEAD;
      total++; if (x_op1 !== exp_v) begin bad++; $display("FAIL b2b_x_op1: got %h want %h", x_op1, exp_v); end
      total++; if (w_data !== 32'h10) begin bad++; $display("FAIL b2b_w_data: got %h want 10", w_data); end
   endtask

   task automatic test_priority();
      drain();
      issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      arith = 32'h2;
      step();
      bubble(); arith = 32'h1;
      step();
      issue(5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'hBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      #1;
      exp_h = !FWD;
      total++; if (hazard !== exp_h) begin bad++; $display("FAIL prio_hazard: got %b want %b", hazard, exp_h); end
      step();
      exp_v = FWD ? 32'h1 : 32'hBEEF;
      total++; if (x_op2 !== exp_v) begin bad++; $display("FAIL prio_m_over_w: got %h want %h", x_op2, exp_v); end
      issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h4444, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      #1;
      total++; if (hazard !== exp_h) begin bad++; $display("FAIL prio_w_hazard: got %b want %b", hazard, exp_h); end
      step();
      exp_v = FWD ? 32'h1 : 32'h4444;
      total++; if (x_op1 !== exp_v) begin bad++; $display("FAIL prio_w_fwd: got %h want %h", x_op1, exp_v); end
      drain();
      issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      arith = 32'h55;
      step();
      bubble(); arith = 32'h66;
      step();
      issue(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      #1;
      total++; if (hazard !== 1'b0) begin bad++; $display("FAIL r0_hazard: got %b want 0", hazard); end
      step();
      total++; if (x_op2 !== 32'h1234) begin bad++; $display("FAIL r0_no_fwd: got %h want 1234", x_op2); end
   endtask

   task automatic test_stall();
      drain();
      issue(5'd0, 5'd0, 5'd1, 1'b1, 32'h11, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd2, 1'b1, 32'h22, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      arith = 32'hA1;
      step();
      issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h33, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      arith = 32'hA2;
      step();
      total++; if (w_we !== 1'b1 || w_data !== 32'hA1 || w_rd !== 5'd1) begin bad++; $display("FAIL stall_pre_wb: got we=%b d=%h rd=%0d want 1 a1 1", w_we, w_data, w_rd); end
      stall = 1'b1; bubble(); arith = 32'hA3;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (x_op1 !== 32'h33 || m_alu !== 32'hA2 || w_data !== 32'hA1) begin bad++; $display("FAIL stall_hold_%0d: got x=%h m=%h w=%h want 33 a2 a1", i, x_op1, m_alu, w_data); end
         total++; if ({x_valid, m_valid, w_we} !== 3'b110) begin bad++; $display("FAIL stall_flags_%0d: got %b want 110", i, {x_valid, m_valid, w_we}); end
      end
      stall = 1'b0;
      step();
      total++; if (w_we !== 1'b1 || w_data !== 32'hA2 || w_rd !== 5'd2) begin bad++; $display("FAIL stall_rel_i2: got we=%b d=%h rd=%0d want 1 a2 2", w_we, w_data, w_rd); end
      step();
      total++; if (w_we !== 1'b1 || w_data !== 32'hA3 || w_rd !== 5'd3) begin bad++; $display("FAIL stall_rel_i3: got we=%b d=%h rd=%0d want 1 a3 3", w_we, w_data, w_rd); end
      step();
      total++; if (w_we !== 1'b0) begin bad++; $display("FAIL stall_no_dup: got %b want 0", w_we); end
   endtask

   task automatic test_flush();
      drain();
      issue(5'd0, 5'd0, 5'd4, 1'b1, 32'h44, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd6, 1'b1, 32'h66, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      arith = 32'hB1;
      step();
      stall = 1'b1; flush = 1'b1;
      issue(5'd0, 5'd0, 5'd8, 1'b1, 32'h88, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      arith = 32'hB2;
      step();
      total++; if ({x_valid, m_valid} !== 2'b00) begin bad++; $display("FAIL flush_valids: got %b want 00", {x_valid, m_valid}); end
      total++; if (w_we !== 1'b1 || w_data !== 32'hB1 || w_rd !== 5'd4) begin bad++; $display("FAIL flush_wb: got we=%b d=%h rd=%0d want 1 b1 4", w_we, w_data, w_rd); end
      stall = 1'b0; flush = 1'b0; bubble();
      step();
      total++; if (w_we !== 1'b0) begin bad++; $display("FAIL flush_killed: got %b want 0", w_we); end
   endtask

   task automatic test_reset_mid();
      drain();
      arith = 32'h77;
      issue(5'd0, 5'd0, 5'd11, 1'b1, 32'h5, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd12, 1'b1, 32'h6, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      issue(5'd0, 5'd0, 5'd13, 1'b1, 32'h7, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, 2'd0, 2'd0);
      step();
      #2 rst = 1'b1;
      #1;
      total++; if (x_op1 !== 32'h0 || x_op2 !== 32'h0 || m_alu !== 32'h0) begin bad++; $display("FAIL rstm_data: got %h %h %h want 0 0 0", x_op1, x_op2, m_alu); end
      total++; if (w_data !== 32'h0 || w_rd !== 5'd0) begin bad++; $display("FAIL rstm_wb: got d=%h rd=%0d want 0 0", w_data, w_rd); end
      total++; if ({x_valid, m_valid, w_we, hazard} !== 4'b0000) begin bad++; $display("FAIL rstm_flags: got %b want 0000", {x_valid, m_valid, w_we, hazard}); end
      #2 rst = 1'b0;
      bubble();
      step();
      total++; if ({x_valid, m_valid, w_we} !== 3'b000) begin bad++; $display("FAIL rstm_post1: got %b want 000", {x_valid, m_valid, w_we}); end
      step();
      total++; if (w_we !== 1'b0) begin bad++; $display("FAIL rstm_post2: got %b want 0", w_we); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      d_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd_we = 1'b0;
      reg1 = 32'h0; reg2 = 32'h0; imm = 32'h0; pc = 32'h0;
      op1_sel = 1'b0; op2_sel = 1'b0; alu_sel = 2'd0; w_sel = 2'd0;
      arith = 32'h0; logical = 32'h0; shift = 32'h0; load = 32'h0;
      test_reset();
      test_latency();
      test_alu_select();
      test_load_pc4();
      test_back_to_back();
      test_priority();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
